// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the MAC receive and transmit paths:
// receive FSM encoding, framing constants and the byte-wide CRC-32 step.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP,
    ST_STATUS
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;  // reflected 0x04C11DB7
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [3:0]  HDR_DST_LAST  = 4'd5;
  localparam logic [3:0]  HDR_LAST      = 4'd13;
  localparam logic [2:0]  PRE_MAX       = 3'd7;
  localparam logic [2:0]  PIPE_FULL     = 3'd5;           // 4-byte delay line + pending byte

  // One byte of reflected CRC-32, LSB of the data first as on the wire.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/CRC32_D8.sv
// Byte-serial Ethernet CRC-32. The register reseeds whenever i_en is low, so a
// frame is simply a contiguous run of enabled bytes; o_crc carries the final XOR.
module CRC32_D8 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  import eth_pkg::*;

  logic [31:0] crc_q;

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    crc_q <= CRC32_INIT;
    else if (i_en) crc_q <= crc32_next(crc_q, i_data);
    else           crc_q <= CRC32_INIT;
  end

  assign o_crc = ~crc_q;

endmodule

// File: rtl/mac_rx.sv
// GMII receive MAC: preamble/SFD sync, destination filter, header capture and
// FCS stripping through a 4-byte delay line, with a one-cycle verdict pulse.
module mac_rx #(
  parameter logic [47:0] P_LOCAL_MAC = 48'h00_00_00_00_00_00,
  parameter int          P_CRC_CHECK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_local_mac,
  input  logic        i_local_mac_valid,
  input  logic [7:0]  i_GMII_data,
  input  logic        i_GMII_valid,
  output logic [15:0] o_recv_type,
  output logic [47:0] o_recv_source_mac,
  output logic [7:0]  o_recv_data,
  output logic        o_recv_valid,
  output logic        o_recv_last,
  output logic        o_status_valid,
  output logic        o_crc_err,
  output logic        o_frame_err,
  output logic [15:0] o_recv_len
);
  import eth_pkg::*;

  rx_state_t   state_q, state_d;
  logic        valid_d, rise;
  logic [47:0] mac_q, cmp_mac;
  logic [2:0]  pre_cnt;
  logic [3:0]  hdr_cnt;
  logic [55:0] hdr_sr;
  logic [7:0]  dl [4];
  logic [2:0]  dl_cnt, pay_cnt;
  logic [7:0]  pending;
  logic [15:0] len_cnt;
  logic        ferr_q, crc_bad_q;
  logic [47:0] dst_word;
  logic        dst_match, crc_en, crc_mismatch;
  logic [31:0] crc, fcs;

  assign rise      = i_GMII_valid && !valid_d;
  assign dst_word  = {hdr_sr[39:0], i_GMII_data};
  assign dst_match = (dst_word == cmp_mac) || (dst_word == BROADCAST_MAC);

  // The CRC consumes bytes as they fall out of the delay line, so when valid
  // drops it covers everything up to the last payload byte and dl holds the FCS.
  assign crc_en       = i_GMII_valid && (state_q inside {ST_HEADER, ST_PAYLOAD}) && (dl_cnt == 3'd4);
  assign fcs          = {dl[0], dl[1], dl[2], dl[3]};
  assign crc_mismatch = (P_CRC_CHECK != 0) && (fcs != crc);

  CRC32_D8 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (crc_en),
    .i_data (dl[3]),
    .o_crc  (crc)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_STATUS: begin
        state_d = ST_IDLE;
        if (rise) state_d = (i_GMII_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!i_GMII_valid)                     state_d = ST_STATUS;
        else if (i_GMII_data == PREAMBLE_BYTE) state_d = (pre_cnt == PRE_MAX) ? ST_DROP : ST_PREAMBLE;
        else if (i_GMII_data == SFD_BYTE)      state_d = ST_HEADER;
        else                                   state_d = ST_DROP;
      end
      ST_HEADER: begin
        if (!i_GMII_valid)                             state_d = ST_STATUS;
        else if (hdr_cnt == HDR_DST_LAST && !dst_match) state_d = ST_DROP;
        else if (hdr_cnt == HDR_LAST)                   state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: if (!i_GMII_valid) state_d = ST_STATUS;
      ST_DROP:    if (!i_GMII_valid) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      // valid_d starts high so a frame already in flight at release is not a rising edge.
      valid_d           <= 1'b1;
      mac_q             <= P_LOCAL_MAC;
      cmp_mac           <= P_LOCAL_MAC;
      pre_cnt           <= '0;
      hdr_cnt           <= '0;
      hdr_sr            <= '0;
      // NOTE: the delay line is only four flops and feeds the FCS compare, so
      // it is reset with everything else rather than left as unreset storage.
      for (int i = 0; i < 4; i++) dl[i] <= '0;
      dl_cnt            <= '0;
      pay_cnt           <= '0;
      pending           <= '0;
      len_cnt           <= '0;
      ferr_q            <= 1'b0;
      crc_bad_q         <= 1'b0;
      o_recv_type       <= '0;
      o_recv_source_mac <= '0;
      o_recv_data       <= '0;
      o_recv_valid      <= 1'b0;
      o_recv_last       <= 1'b0;
      o_status_valid    <= 1'b0;
      o_crc_err         <= 1'b0;
      o_frame_err       <= 1'b0;
      o_recv_len        <= '0;
    end else begin
      valid_d        <= i_GMII_valid;
      o_recv_valid   <= 1'b0;
      o_recv_last    <= 1'b0;
      o_status_valid <= 1'b0;

      if (i_local_mac_valid) mac_q <= i_local_mac;

      if (state_q inside {ST_HEADER, ST_PAYLOAD}) begin
        if (i_GMII_valid) begin
          dl[0] <= i_GMII_data;
          dl[1] <= dl[0];
          dl[2] <= dl[1];
          dl[3] <= dl[2];
          if (dl_cnt != 3'd4) dl_cnt <= dl_cnt + 3'd1;
        end
      end else begin
        dl_cnt <= '0;
      end

      case (state_q)
        ST_IDLE, ST_STATUS: begin
          // The compare address is frozen here so a mid-frame update waits for the next frame.
          cmp_mac <= mac_q;
          pre_cnt <= 3'd1;
          if (state_q == ST_STATUS) begin
            o_status_valid <= 1'b1;
            o_crc_err      <= crc_bad_q;
            o_frame_err    <= ferr_q;
            o_recv_len     <= len_cnt;
          end
        end
        ST_PREAMBLE: begin
          hdr_cnt <= '0;
          if (i_GMII_valid) begin
            pre_cnt <= pre_cnt + 3'd1;
          end else begin
            ferr_q    <= 1'b1;
            crc_bad_q <= 1'b0;
            len_cnt   <= '0;
          end
        end
        ST_HEADER: begin
          pay_cnt <= '0;
          len_cnt <= '0;
          if (i_GMII_valid) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            hdr_sr  <= {hdr_sr[47:0], i_GMII_data};
            if (hdr_cnt == HDR_LAST) begin
              o_recv_source_mac <= hdr_sr[55:8];
              o_recv_type       <= {hdr_sr[7:0], i_GMII_data};
            end
          end else begin
            ferr_q    <= 1'b1;
            crc_bad_q <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          if (i_GMII_valid) begin
            if (pay_cnt != PIPE_FULL) pay_cnt <= pay_cnt + 3'd1;
            if (pay_cnt >= 3'd4)      pending <= dl[3];
            if (pay_cnt == PIPE_FULL) begin
              o_recv_data  <= pending;
              o_recv_valid <= 1'b1;
              len_cnt      <= sat_inc16(len_cnt);
            end
          end else if (pay_cnt == PIPE_FULL) begin
            o_recv_data  <= pending;
            o_recv_valid <= 1'b1;
            o_recv_last  <= 1'b1;
            len_cnt      <= sat_inc16(len_cnt);
            ferr_q       <= 1'b0;
            crc_bad_q    <= crc_mismatch;
          end else begin
            // Four bytes or fewer after the header: not even a complete FCS.
            ferr_q    <= 1'b1;
            crc_bad_q <= 1'b0;
            len_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac_rx.md
MAC_RX -- requirements
Module: mac_rx

Interface
REQ-001 SHALL have parameter P_LOCAL_MAC, default 48'h00_00_00_00_00_00, reset value of the local MAC address.
REQ-002 SHALL have parameter P_CRC_CHECK, default 1; 0 means the FCS is not checked and o_crc_err is always 0.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_local_mac  input  48  new local MAC address, MSB = first byte on the wire.
REQ-006 SHALL have port i_local_mac_valid  input  1  loads i_local_mac.
REQ-007 SHALL have port i_GMII_data  input  8  received GMII byte.
REQ-008 SHALL have port i_GMII_valid  input  1  GMII RX_DV; high for the whole frame, preamble through FCS.
REQ-009 SHALL have port o_recv_type  output  16  EtherType of the current frame.
REQ-010 SHALL have port o_recv_source_mac  output  48  source MAC of the current frame.
REQ-011 SHALL have port o_recv_data  output  8  payload byte, FCS excluded.
REQ-012 SHALL have port o_recv_valid  output  1  o_recv_data is valid.
REQ-013 SHALL have port o_recv_last  output  1  marks the last payload byte.
REQ-014 SHALL have port o_status_valid  output  1  one-cycle pulse, frame verdict.
REQ-015 SHALL have port o_crc_err  output  1  FCS mismatch; qualified by o_status_valid.
REQ-016 SHALL have port o_frame_err  output  1  malformed or runt frame; qualified by o_status_valid.
REQ-017 SHALL have port o_recv_len  output  16  payload byte count, saturating at 16'hFFFF; qualified by o_status_valid.

Function
REQ-018 SHALL start a frame only on a rising edge of i_GMII_valid; when valid is already high at reset release, the block SHALL ignore the rest of that frame.
REQ-019 SHALL use states IDLE, PREAMBLE, HEADER, PAYLOAD, DROP, STATUS.
REQ-020 PREAMBLE SHALL accept 1-7 bytes of 8'h55 followed by 8'hD5, then go to HEADER. Any other byte, or an eighth 8'h55, SHALL send the FSM to DROP.
REQ-021 HEADER SHALL capture 14 bytes: destination MAC, then source MAC, then type, MSB first. The byte counter runs 0-13.
REQ-022 The frame SHALL be accepted only when the destination equals the local MAC or 48'hFF_FF_FF_FF_FF_FF. On a mismatch, the FSM SHALL go to DROP after header byte 5, with no output and no status.
REQ-023 o_recv_type and o_recv_source_mac SHALL update once header byte 13 is captured, and SHALL hold until the next accepted frame.
REQ-024 PAYLOAD SHALL pass bytes through a 4-byte delay line plus a pending register. A byte SHALL be emitted on o_recv_data/o_recv_valid, with o_recv_last=0, when a newer byte pushes it out.
REQ-025 On the falling edge of i_GMII_valid in PAYLOAD, the pending byte SHALL be emitted with o_recv_last=1, and the delay line, holding the FCS, SHALL be compared against the CRC.
REQ-026 The CRC SHALL be CRC-32 (init all ones, reflected, final XOR) over the destination MAC through the last payload byte. Received FCS byte order SHALL be crc[7:0] first, matching the transmit block.
REQ-027 o_status_valid SHALL pulse exactly 1 cycle after o_recv_last, then the FSM SHALL return to IDLE.
REQ-028 If valid falls in PREAMBLE or HEADER, or in PAYLOAD with at most 4 bytes received, the block SHALL emit no o_recv_last and SHALL give one o_status_valid pulse with o_frame_err=1, o_crc_err=0 and o_recv_len=0.
REQ-029 DROP SHALL hold until i_GMII_valid is low, then return to IDLE. A dropped frame SHALL produce no status.
REQ-030 A new frame whose valid rises in the STATUS cycle SHALL be accepted; the gap SHALL never be 0 cycles, because valid must first fall.
REQ-031 A pulse on i_local_mac_valid SHALL take effect from the next frame's header compare.

Reset
REQ-032 Asynchronous active-low reset SHALL set: all outputs 0; local MAC = P_LOCAL_MAC; FSM = IDLE; delay line, counters and CRC register cleared, with CRC = 32'hFFFFFFFF.
REQ-033 Reset mid-frame SHALL abort it with no last and no status.

Structure
REQ-034 State encoding, the preamble/SFD constants, the broadcast MAC and the CRC polynomial SHALL live in a shared package, eth_pkg.
REQ-035 The CRC SHALL be one sub-module, CRC32_D8, shared with the transmit path: ports i_clk, i_rst, i_en, i_data, o_crc.

Verification
REQ-036 Test: 7x55, D5, dst=local, src=02:11:22:33:44:55, type 0800, 46 payload bytes 00..2D, correct FCS from the transmit block. Required: 46 valid beats, last on byte 2D, status with crc_err=0, frame_err=0, len=46.
REQ-037 Test: same frame with the first FCS byte XOR 8'h01. Required: identical data stream, crc_err=1 in the status pulse.
REQ-038 Test: dst=02:00:00:00:00:99, not local and not broadcast. Required: no o_recv_valid and no status; the next frame, 12 idle cycles later, is received normally.
REQ-039 Test: valid drops after 3 payload bytes. Required: no data, a single status pulse with frame_err=1 and len=0.
REQ-040 Test: preamble 55 55 AA. Required: DROP, no output; and reset asserted mid-payload gives no last and no status.
